// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rx_deglitch_pkg.sv
// Shared types and constants for the rx deglitch cell: FSM state encoding,
// default depths and the legal parameter ranges.
package gf180mcu_fd_sc_mcu7t5v0__rx_pkg;

   localparam int RX_SYNC_STAGES_DEF = 2;
   localparam int RX_FILT_CNT_DEF    = 4;
   localparam int RX_SYNC_STAGES_MIN = 2;
   localparam int RX_SYNC_STAGES_MAX = 4;
   localparam int RX_FILT_CNT_MIN    = 1;
   localparam int RX_FILT_CNT_MAX    = 255;

   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      QUAL_HI   = 2'b01,
      STABLE_HI = 2'b11,
      QUAL_LO   = 2'b10
   } rx_state_e;

   // Out-of-range parameters are pulled back into the legal window.
   function automatic int rx_clamp(input int val, input int lo, input int hi);
      int res;
      if (val < lo) begin
         res = lo;
      end else if (val > hi) begin
         res = hi;
      end else begin
         res = val;
      end
      return res;
   endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rx_deglitch_if.sv
// Receive-side signal bundle: the raw level and the filtered level with its
// edge pulses. The master drives the raw level, the slave returns the rest.
interface gf180mcu_fd_sc_mcu7t5v0__rx_deglitch_if;

   logic i;
   logic z;
   logic zr;
   logic zf;

   modport master (
      output i,
      input  z,
      input  zr,
      input  zf
   );

   modport slave (
      input  i,
      output z,
      output zr,
      output zf
   );

endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rx_deglitch_sync.sv
// Plain flop-chain synchronizer with synchronous active-high reset; the
// output is the last stage of the chain.
module gf180mcu_fd_sc_mcu7t5v0__rx_sync
   import gf180mcu_fd_sc_mcu7t5v0__rx_pkg::*;
#(
   parameter int DEPTH = RX_SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] chain_q;
   logic [DEPTH-1:0] chain_d;

   // Shift the asynchronous input one stage per clock.
   always_comb begin
      chain_d = {chain_q[DEPTH-2:0], d};
   end

   // Chain register, cleared on reset so no stale level survives.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= {DEPTH{1'b0}};
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q = chain_q[DEPTH-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rx_deglitch.sv
// Synchronizing deglitch filter: Z follows I only after FILT_CNT consecutive
// agreeing samples. Define GF180MCU_FD_SC_MCU7T5V0_RX_EDGE_EN for ZR/ZF pulses.
module gf180mcu_fd_sc_mcu7t5v0__rx_deglitch
   import gf180mcu_fd_sc_mcu7t5v0__rx_pkg::*;
#(
   parameter int SYNC_STAGES = RX_SYNC_STAGES_DEF,
   parameter int FILT_CNT    = RX_FILT_CNT_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic I,
   output logic Z,
   output logic ZR,
   output logic ZF,
   inout  wire  VDD,
   inout  wire  VSS
);

   localparam int SYNC_N = rx_clamp(SYNC_STAGES, RX_SYNC_STAGES_MIN, RX_SYNC_STAGES_MAX);
   localparam int FILT_N = rx_clamp(FILT_CNT, RX_FILT_CNT_MIN, RX_FILT_CNT_MAX);
   localparam int CNT_W  = $clog2(FILT_N + 32'sd1);
   localparam bit FAST_QUAL = (FILT_N == 32'sd1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_N - 32'sd1);

   wire unused_supply_s;
   assign unused_supply_s = VDD ^ VSS;

   logic      s_s;
   rx_state_e state_q;
   rx_state_e state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic      z_q;
   logic      z_d;

   gf180mcu_fd_sc_mcu7t5v0__rx_sync #(
      .DEPTH (SYNC_N)
   ) u_sync (
      .clk (CLK),
      .rst (RST),
      .d   (I),
      .q   (s_s)
   );

   // Qualification FSM: a level must be seen FILT_N samples in a row before
   // Z moves; any disagreeing sample drops back to the current stable state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      z_d     = z_q;
      case (state_q)
         STABLE_LO: begin
            if (s_s) begin
               if (FAST_QUAL) begin
                  state_d = STABLE_HI;
                  z_d     = 1'b1;
                  cnt_d   = CNT_ZERO;
               end else begin
                  state_d = QUAL_HI;
                  cnt_d   = CNT_ONE;
               end
            end else begin
               cnt_d = CNT_ZERO;
            end
         end
         QUAL_HI: begin
            if (s_s) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = STABLE_HI;
                  z_d     = 1'b1;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               state_d = STABLE_LO;
               cnt_d   = CNT_ZERO;
            end
         end
         STABLE_HI: begin
            if (!s_s) begin
               if (FAST_QUAL) begin
                  state_d = STABLE_LO;
                  z_d     = 1'b0;
                  cnt_d   = CNT_ZERO;
               end else begin
                  state_d = QUAL_LO;
                  cnt_d   = CNT_ONE;
               end
            end else begin
               cnt_d = CNT_ZERO;
            end
         end
         QUAL_LO: begin
            if (!s_s) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = STABLE_LO;
                  z_d     = 1'b0;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               state_d = STABLE_HI;
               cnt_d   = CNT_ZERO;
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = CNT_ZERO;
            z_d     = 1'b0;
         end
      endcase
   end

   // FSM, counter and filtered level registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= STABLE_LO;
         cnt_q   <= CNT_ZERO;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
      end
   end

   assign Z = z_q;

`ifdef GF180MCU_FD_SC_MCU7T5V0_RX_EDGE_EN
   logic zr_q;
   logic zr_d;
   logic zf_q;
   logic zf_d;

   // Edge pulses are registered alongside Z so they line up with its change.
   always_comb begin
      zr_d = z_d & ~z_q;
      zf_d = ~z_d & z_q;
   end

   // Edge pulse registers; reset never produces a pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         zr_q <= 1'b0;
         zf_q <= 1'b0;
      end else begin
         zr_q <= zr_d;
         zf_q <= zf_d;
      end
   end

   assign ZR = zr_q;
   assign ZF = zf_q;
`else
   assign ZR = 1'b0;
   assign ZF = 1'b0;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rx_deglitch.sv
// Directed bench for the rx deglitch cell: a vector table for the default
// configuration plus hand sequences for reset-in-qualify and a fast variant.
module tb_gf180mcu_fd_sc_mcu7t5v0__rx_deglitch;
   import gf180mcu_fd_sc_mcu7t5v0__rx_pkg::*;

`ifdef GF180MCU_FD_SC_MCU7T5V0_RX_EDGE_EN
   localparam bit EDGE_ON = 1'b1;
`else
   localparam bit EDGE_ON = 1'b0;
`endif
   localparam int NE = 0;
   localparam int RE = 1;
   localparam int FE = 2;

   typedef struct {
      string name;
      logic  rst;
      logic  i;
      logic  z;
      logic  zr;
      logic  zf;
   } vec_t;

   logic clk;
   logic rst;
   logic rst3;
   logic i3;
   logic z3;
   logic zr3;
   logic zf3;
   wire  vdd_s;
   wire  vss_s;
   assign vdd_s = 1'b1;
   assign vss_s = 1'b0;

   int n_checks;
   int n_fail;
   vec_t tbl[$];

   gf180mcu_fd_sc_mcu7t5v0__rx_deglitch_if rx ();

   gf180mcu_fd_sc_mcu7t5v0__rx_deglitch dut (
      .CLK (clk),
      .RST (rst),
      .I   (rx.i),
      .Z   (rx.z),
      .ZR  (rx.zr),
      .ZF  (rx.zf),
      .VDD (vdd_s),
      .VSS (vss_s)
   );

   gf180mcu_fd_sc_mcu7t5v0__rx_deglitch #(
      .SYNC_STAGES (3),
      .FILT_CNT    (1)
   ) dut3 (
      .CLK (clk),
      .RST (rst3),
      .I   (i3),
      .Z   (z3),
      .ZR  (zr3),
      .ZF  (zf3),
      .VDD (vdd_s),
      .VSS (vss_s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic r, input logic iv, input logic z, input int e);
      vec_t v;
      v.name = nm;
      v.rst  = r;
      v.i    = iv;
      v.z    = z;
      v.zr   = EDGE_ON && (e == RE);
      v.zf   = EDGE_ON && (e == FE);
      tbl.push_back(v);
   endtask

   initial begin
      int   rise_at;
      int   zr_n;
      int   zf_n;
      logic h [0:63];
      logic exp_z;
      logic prev_z;

      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      rx.i     = 1'b0;
      rst3     = 1'b1;
      i3       = 1'b0;

      // Inputs are applied before the edge; expectations hold just after it.
      repeat (3) add("rst_hold", 1'b1, 1'b1, 1'b0, NE);
      for (int k = 1; k <= 8; k++) add("release_rise", 1'b0, 1'b1, k >= 6, (k == 6) ? RE : NE);
      repeat (3) add("glitch_lo", 1'b0, 1'b0, 1'b1, NE);
      repeat (6) add("glitch_lo_recover", 1'b0, 1'b1, 1'b1, NE);
      for (int k = 1; k <= 8; k++) add("held_fall", 1'b0, 1'b0, k < 6, (k == 6) ? FE : NE);
      for (int k = 1; k <= 10; k++) add("pulse3_reject", 1'b0, k <= 3, 1'b0, NE);
      for (int k = 1; k <= 12; k++)
         add("pulse4_pass", 1'b0, k <= 4, (k >= 6) && (k <= 9), (k == 6) ? RE : ((k == 10) ? FE : NE));
      for (int k = 1; k <= 8; k++) add("hold_hi", 1'b0, 1'b1, k >= 6, (k == 6) ? RE : NE);

      step();
      check("reset_z", rx.z, 1'b0);
      check("reset_zr", rx.zr, 1'b0);
      check("reset_zf", rx.zf, 1'b0);

      foreach (tbl[k]) begin
         rst  = tbl[k].rst;
         rx.i = tbl[k].i;
         step();
         check({tbl[k].name, "_z"}, rx.z, tbl[k].z);
         check({tbl[k].name, "_zr"}, rx.zr, tbl[k].zr);
         check({tbl[k].name, "_zf"}, rx.zf, tbl[k].zf);
      end

      // Three-cycle low glitch from STABLE_HI must land back in STABLE_HI.
      rx.i = 1'b0;
      repeat (3) begin
         step();
         check("glitch2_z", rx.z, 1'b1);
      end
      rx.i = 1'b1;
      repeat (6) begin
         step();
         check("glitch2_z", rx.z, 1'b1);
         check("glitch2_zf", rx.zf, 1'b0);
      end
      check("glitch2_state", 32'(dut.state_q), 32'(STABLE_HI));
      check("glitch2_cnt", 32'(dut.cnt_q), 32'd0);

      // Reset while qualifying high with CNT=2.
      rx.i = 1'b0;
      repeat (8) step();
      check("settle_lo_z", rx.z, 1'b0);
      check("settle_lo_state", 32'(dut.state_q), 32'(STABLE_LO));
      rx.i = 1'b1;
      repeat (4) step();
      check("qual_state", 32'(dut.state_q), 32'(QUAL_HI));
      check("qual_cnt", 32'(dut.cnt_q), 32'd2);
      rst = 1'b1;
      step();
      check("rst_qual_z", rx.z, 1'b0);
      check("rst_qual_zr", rx.zr, 1'b0);
      check("rst_qual_cnt", 32'(dut.cnt_q), 32'd0);
      check("rst_qual_state", 32'(dut.state_q), 32'(STABLE_LO));
      repeat (2) step();
      rst     = 1'b0;
      rise_at = 0;
      zr_n    = 0;
      zf_n    = 0;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (rise_at == 0 && rx.z === 1'b1) rise_at = c;
         zr_n += int'(rx.zr);
         zf_n += int'(rx.zf);
      end
      check("release_rise_edge", rise_at, 32'd6);
      check("release_zr_pulses", zr_n, EDGE_ON ? 32'd1 : 32'd0);
      check("release_zf_pulses", zf_n, 32'd0);

      // Fast variant: Z is I delayed by four edges, edge pulses alternate.
      rst3 = 1'b0;
      i3   = 1'b0;
      repeat (6) step();
      check("fast_idle_z", z3, 1'b0);
      prev_z = 1'b0;
      for (int k = 0; k < 40; k++) begin
         i3   = ((k / 5) % 2 == 0) ? 1'b1 : 1'b0;
         h[k] = i3;
         step();
         exp_z = (k >= 3) ? h[k-3] : 1'b0;
         check("fast_z", z3, exp_z);
         check("fast_zr", zr3, EDGE_ON & exp_z & ~prev_z);
         check("fast_zf", zf3, EDGE_ON & ~exp_z & prev_z);
         prev_z = exp_z;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__rx_deglitch.md
GF180MCU_FD_SC_MCU7T5V0__RX_DEGLITCH -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__rx_deglitch

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops (legal 2..4).
REQ-002 SHALL have parameter FILT_CNT, default 4, giving the consecutive stable cycles required before Z changes (legal 1..255).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port I, input, 1 bit: asynchronous receive-side signal, as driven by a buffer cell.
REQ-006 SHALL have port Z, output, 1 bit: synchronized, deglitched level of I.
REQ-007 SHALL have port ZR, output, 1 bit: one-cycle pulse when Z rises.
REQ-008 SHALL have port ZF, output, 1 bit: one-cycle pulse when Z falls.
REQ-009 SHALL have ports VDD and VSS, inout, 1 bit each: supply pins, with no functional use.

Function
REQ-010 SHALL pass I through a SYNC_STAGES-deep flop chain; the last stage is S.
REQ-011 SHALL run an FSM with four states: STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO.
REQ-012 SHALL hold a qualification counter CNT of width $clog2(FILT_CNT+1).
REQ-013 In STABLE_LO with S=1: if FILT_CNT=1, go to STABLE_HI and set Z=1 on that edge; otherwise go to QUAL_HI with CNT=1.
REQ-014 In QUAL_HI with S=1: increment CNT. When CNT=FILT_CNT-1, go to STABLE_HI, set Z=1 and clear CNT.
REQ-015 In QUAL_HI with S=0: return to STABLE_LO, clear CNT, leave Z unchanged (glitch rejected).
REQ-016 The QUAL_LO and STABLE_HI rules SHALL mirror REQ-013..015 with polarities swapped.
REQ-017 The latency from a held I change to the Z change SHALL be exactly SYNC_STAGES+FILT_CNT rising edges (6 at defaults).
REQ-018 A pulse on I shorter than FILT_CNT cycles after synchronization SHALL never change Z.
REQ-019 ZR SHALL equal 1 for exactly the cycle in which Z has just become 1; ZF likewise for Z becoming 0. ZR and ZF SHALL never both be 1.
REQ-020 CNT SHALL never exceed FILT_CNT-1 and SHALL never wrap.

Reset
REQ-021 When RST=1 at a CLK edge, all synchronizer flops SHALL be set to 0, with Z=0, ZR=0, ZF=0, CNT=0 and state STABLE_LO.
REQ-022 Reset during QUAL_* SHALL abort qualification and produce no ZR/ZF pulse. I is ignored while RST=1.
REQ-023 After RST deasserts with I held at 1, Z SHALL rise SYNC_STAGES+FILT_CNT edges later, with one ZR pulse.

Configuration
REQ-024 Macro GF180MCU_FD_SC_MCU7T5V0_RX_EDGE_EN SHALL compile in the edge-pulse logic.
REQ-025 With the macro defined, ZR and ZF SHALL behave per REQ-019.
REQ-026 Without the macro, ZR and ZF SHALL be constant 0, no edge flops SHALL exist, and Z behaviour SHALL be unchanged.

Structure
REQ-027 Package gf180mcu_fd_sc_mcu7t5v0__rx_pkg SHALL hold the FSM state enum, the default SYNC_STAGES and FILT_CNT constants, and the legal-range limits.
REQ-028 The synchronizer SHALL be a separate sub-module, gf180mcu_fd_sc_mcu7t5v0__rx_sync, parameterized by depth, with synchronous active-high reset.

Verification
REQ-029 Hold RST=1 for 3 cycles with I=1, then release: Z rises on the 6th edge after release, ZR=1 for that single cycle, ZF stays 0.
REQ-030 From STABLE_HI, drive I=0 for 3 cycles and then back to 1: Z stays 1, ZR/ZF stay 0, and the FSM returns to STABLE_HI.
REQ-031 From STABLE_LO, drive I=1 for exactly 4 synchronized cycles: Z=1 at edge 6 after the I change; hold I and check Z stays 1.
REQ-032 Assert RST during QUAL_HI with CNT=2: the next cycle shows Z=0, CNT=0, STABLE_LO, and no ZR.
REQ-033 With FILT_CNT=1 and SYNC_STAGES=3, toggle I every 5 cycles: Z follows with 4-cycle latency and ZR/ZF alternate.
REQ-034 Build without GF180MCU_FD_SC_MCU7T5V0_RX_EDGE_EN and rerun REQ-029: Z timing is identical and ZR=ZF=0 throughout.
